// File: rtl/display_input_scanner.sv
// display_input_scanner
//   Input front-end for the Cambridge display board. Scans the button shift
//   register (parallel-load, clocked shift, serial out), debounces each button,
//   decodes N_DIALS quadrature dials into wrapping counters and presents all of
//   it to the HPS as an Avalon-MM slave with a press-event interrupt.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   avs_address    word address (0 BUTTONS, 1 EVENTS, 2+i DIALi, 15 STATUS)
//   avs_read       read strobe, avs_readdata valid the following cycle
//   avs_write      write strobe
//   avs_writedata  write data
//   avs_readdata   registered read data
//   irq            high while any press-event bit is set
//   shift_load_n   to SHIFT_LOAD, low = parallel load
//   shift_clk      to SHIFT_CLKIN
//   shift_out      from SHIFT_OUT, low = button pressed
//   dial_a/dial_b  raw quadrature phases, one bit per dial

module display_input_scanner #(
  parameter int N_BUTTONS = 16,
  parameter int N_DIALS   = 2,
  parameter int CNT_W     = 16,
  parameter int SHIFT_DIV = 64,
  parameter int DEBOUNCE  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  output logic [31:0]        avs_readdata,
  output logic               irq,
  output logic               shift_load_n,
  output logic               shift_clk,
  input  logic               shift_out,
  input  logic [N_DIALS-1:0] dial_a,
  input  logic [N_DIALS-1:0] dial_b
);

  localparam int IDX_W = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1;
  localparam int DIV_W = $clog2(SHIFT_DIV);
  localparam int RUN_W = $clog2(DEBOUNCE) + 1;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_COMMIT
  } state_t;

  state_t                 state, state_next;
  logic [DIV_W-1:0]       div_cnt;
  logic                   tick;
  logic [IDX_W-1:0]       idx;
  logic [N_BUTTONS-1:0]   frame;
  logic [1:0]             shift_sync;
  logic [N_BUTTONS-1:0]   btn_db;
  logic [RUN_W-1:0]       run_cnt [N_BUTTONS];
  logic [N_BUTTONS-1:0]   flip;
  logic [N_BUTTONS-1:0]   press_set;
  logic [N_BUTTONS-1:0]   events;
  logic [N_BUTTONS-1:0]   events_w1c;
  logic [N_DIALS-1:0]     a_s1, a_s2, b_s1, b_s2, a_prev, b_prev;
  logic [N_DIALS-1:0]     dial_inc, dial_dec, dial_bad;
  logic [CNT_W-1:0]       dial_cnt [N_DIALS];
  logic [N_DIALS-1:0]     dial_err;
  logic [N_DIALS-1:0]     err_w1c;
  logic [31:0]            rd_mux;
  logic                   unused_wdata;

  // Upper write-data bits are not stored by any register.
  assign unused_wdata = &{1'b0, avs_writedata};

  assign tick = (div_cnt == DIV_W'(SHIFT_DIV - 1));
  assign irq  = |events;

  // Tick divider; restarted on COMMIT so every frame has identical timing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (state == ST_COMMIT || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Scan FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD:     if (tick) state_next = ST_SHIFT_LO;
      ST_SHIFT_LO: if (tick) state_next = (idx == '0) ? ST_COMMIT : ST_SHIFT_HI;
      ST_SHIFT_HI: if (tick) state_next = ST_SHIFT_LO;
      ST_COMMIT:   state_next = ST_LOAD;
      default:     state_next = ST_LOAD;
    endcase
  end

  // Pin outputs are registered from the next state so they track the FSM
  // exactly while still resetting to the idle levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_LOAD;
      shift_load_n <= 1'b1;
      shift_clk    <= 1'b0;
      idx          <= IDX_W'(N_BUTTONS - 1);
      frame        <= '0;
      shift_sync   <= '0;
    end else begin
      state        <= state_next;
      shift_load_n <= (state_next != ST_LOAD);
      shift_clk    <= (state_next == ST_SHIFT_HI);
      shift_sync   <= {shift_sync[0], shift_out};
      if (state == ST_SHIFT_LO && tick) begin
        frame[idx] <= ~shift_sync[1];
      end
      if (state == ST_SHIFT_HI && tick) begin
        idx <= idx - 1'b1;
      end else if (state == ST_COMMIT) begin
        idx <= IDX_W'(N_BUTTONS - 1);
      end
    end
  end

  // A bit flips on the frame that completes DEBOUNCE consecutive disagreements.
  always_comb begin
    flip      = '0;
    press_set = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (state == ST_COMMIT && frame[i] != btn_db[i] &&
          run_cnt[i] == RUN_W'(DEBOUNCE - 1)) begin
        flip[i] = 1'b1;
      end
      press_set[i] = flip[i] & frame[i];
    end
  end

  // Debounced state and per-bit run counters, updated only at frame commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_db <= '0;
      for (int i = 0; i < N_BUTTONS; i++) run_cnt[i] <= '0;
    end else if (state == ST_COMMIT) begin
      btn_db <= btn_db ^ flip;
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (frame[i] == btn_db[i] || flip[i]) run_cnt[i] <= '0;
        else                                  run_cnt[i] <= run_cnt[i] + 1'b1;
      end
    end
  end

  // W1C masks; a set arriving in the same cycle as its clear wins.
  always_comb begin
    events_w1c = '0;
    err_w1c    = '0;
    if (avs_write && avs_address == 4'd1)  events_w1c = avs_writedata[N_BUTTONS-1:0];
    if (avs_write && avs_address == 4'd15) err_w1c    = avs_writedata[N_DIALS-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      events   <= '0;
      dial_err <= '0;
    end else begin
      events   <= (events & ~events_w1c) | press_set;
      dial_err <= (dial_err & ~err_w1c) | dial_bad;
    end
  end

  // Dial phase synchronisers plus the previous-state register for decoding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_s1 <= '0; a_s2 <= '0; a_prev <= '0;
      b_s1 <= '0; b_s2 <= '0; b_prev <= '0;
    end else begin
      a_s1 <= dial_a; a_s2 <= a_s1; a_prev <= a_s2;
      b_s1 <= dial_b; b_s2 <= b_s1; b_prev <= b_s2;
    end
  end

  // Gray decode: {a,b} sequence 00,01,11,10 counts up; both phases moving is invalid.
  always_comb begin
    dial_inc = '0;
    dial_dec = '0;
    dial_bad = '0;
    for (int i = 0; i < N_DIALS; i++) begin
      case ({a_prev[i], b_prev[i], a_s2[i], b_s2[i]})
        4'b0001, 4'b0111, 4'b1110, 4'b1000: dial_inc[i] = 1'b1;
        4'b0100, 4'b1101, 4'b1011, 4'b0010: dial_dec[i] = 1'b1;
        4'b0011, 4'b1100, 4'b0110, 4'b1001: dial_bad[i] = 1'b1;
        default: ;
      endcase
    end
  end

  // Dial counters; a bus write overrides a coincident step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_DIALS; i++) dial_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_DIALS; i++) begin
        if (avs_write && avs_address == 4'(2 + i)) dial_cnt[i] <= avs_writedata[CNT_W-1:0];
        else if (dial_inc[i])                      dial_cnt[i] <= dial_cnt[i] + 1'b1;
        else if (dial_dec[i])                      dial_cnt[i] <= dial_cnt[i] - 1'b1;
      end
    end
  end

  // Read mux over the pre-update register values.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      4'd0:    rd_mux[N_BUTTONS-1:0] = btn_db;
      4'd1:    rd_mux[N_BUTTONS-1:0] = events;
      4'd15:   rd_mux[N_DIALS-1:0]   = dial_err;
      default: begin
        for (int i = 0; i < N_DIALS; i++) begin
          if (avs_address == 4'(2 + i)) rd_mux[CNT_W-1:0] = dial_cnt[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_display_input_scanner.sv
// tb_display_input_scanner
//   Drives the scanner through a behavioural parallel-in/serial-out button
//   register and quadrature dial phases; bus reads push expected values into a
//   scoreboard queue that a separate monitor drains when read data appears.

module tb_display_input_scanner;

  localparam int NB = 16;
  localparam int ND = 2;
  localparam int CW = 16;
  localparam int SD = 4;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [3:0]    avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic          irq;
  logic          shift_load_n;
  logic          shift_clk;
  logic          shift_out;
  logic [ND-1:0] dial_a = '0;
  logic [ND-1:0] dial_b = '0;

  logic [NB-1:0] btn = '0;
  logic [NB-1:0] sr = '0;
  logic          shift_clk_d = 1'b0;

  int total = 0;
  int bad   = 0;
  int p     = 0;
  int frame_clks = 0;

  logic [31:0] exp_q [$];
  string       name_q [$];
  logic        rd_valid = 1'b0;

  display_input_scanner #(
    .N_BUTTONS(NB), .N_DIALS(ND), .CNT_W(CW), .SHIFT_DIV(SD), .DEBOUNCE(DB)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq),
    .shift_load_n(shift_load_n), .shift_clk(shift_clk), .shift_out(shift_out),
    .dial_a(dial_a), .dial_b(dial_b)
  );

  always #5 clk = ~clk;

  // Board shift register: loads while SHIFT_LOAD low, shifts on SHIFT_CLKIN rise.
  always @(posedge clk) begin
    shift_clk_d <= shift_clk;
    if (!shift_load_n)                  sr <= btn;
    else if (shift_clk && !shift_clk_d) sr <= {sr[NB-2:0], 1'b0};
  end
  assign shift_out = ~sr[NB-1];

  // Scoreboard monitor.
  always @(posedge clk) rd_valid <= avs_read;

  always @(negedge clk) begin
    if (rd_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL sb_underflow: read data 0x%08h with nothing expected", avs_readdata);
      end else begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (avs_readdata !== e) begin
          bad++;
          $display("[TB] FAIL %s: got 0x%08h want 0x%08h", n, avs_readdata, e);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic busRead(input logic [3:0] a, input logic [31:0] e, input string n);
    @(posedge clk); #1;
    avs_address = a; avs_read = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  task automatic applyStimulus(input int d, input logic a, input logic b);
    dial_a[d] = a;
    dial_b[d] = b;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Waits for n falling edges of shift_load_n; clks = cycles spent on the last one.
  task automatic waitLoadFall(input int n, output int clks);
    clks = 0;
    for (int k = 0; k < n; k++) begin
      logic prev;
      prev = shift_load_n;
      clks = 0;
      while (1) begin
        @(posedge clk); #1;
        clks++;
        if (prev && !shift_load_n) break;
        prev = shift_load_n;
        if (clks > 2000) begin
          total++; bad++;
          $display("[TB] FAIL load_timeout: got %0d clks without a load, want < 2000", clks);
          break;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset in the middle of a shift phase
    busWrite(4'd2, 32'h0000_ABCD);
    busRead(4'd2, 32'h0000_ABCD, "dial0_prewrite");
    begin
      int c;
      c = 0;
      while (shift_clk !== 1'b1 && c < 2000) begin
        @(posedge clk); #1; c++;
      end
      checkOutput("reached_shift_hi", {31'd0, shift_clk}, 32'd1);
    end
    reset_n = 1'b0;
    #1;
    checkOutput("rst_load_n", {31'd0, shift_load_n}, 32'd1);
    checkOutput("rst_shift_clk", {31'd0, shift_clk}, 32'd0);
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    checkOutput("rst_readdata", avs_readdata, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    busRead(4'd0, 32'd0, "rst_buttons");
    busRead(4'd1, 32'd0, "rst_events");
    busRead(4'd2, 32'd0, "rst_dial0");
    busRead(4'd3, 32'd0, "rst_dial1");
    busRead(4'd15, 32'd0, "rst_status");

    // Buttons 0 and 1 pressed: debounced after the fourth frame
    waitLoadFall(1, p);
    btn = 16'h0003;
    waitLoadFall(3, p);
    busRead(4'd0, 32'd0, "buttons_after_3_frames");
    waitLoadFall(1, p);
    busRead(4'd0, 32'h3, "buttons_after_4_frames");
    busRead(4'd1, 32'h3, "events_after_press");
    checkOutput("irq_after_press", {31'd0, irq}, 32'd1);
    busWrite(4'd1, 32'h1);
    busRead(4'd1, 32'h2, "events_w1c_bit0");
    checkOutput("irq_one_left", {31'd0, irq}, 32'd1);
    busWrite(4'd1, 32'h2);
    checkOutput("irq_cleared", {31'd0, irq}, 32'd0);
    busRead(4'd1, 32'h0, "events_cleared");
    busRead(4'd14, 32'h0, "unmapped_read");

    // Button 5 glitch: three frames only
    waitLoadFall(1, p);
    btn = 16'h0023;
    waitLoadFall(3, p);
    btn = 16'h0003;
    waitLoadFall(3, p);
    busRead(4'd0, 32'h3, "glitch_buttons");
    busRead(4'd1, 32'h0, "glitch_events");
    checkOutput("glitch_irq", {31'd0, irq}, 32'd0);
    busWrite(4'd0, 32'hFFFF_FFFF);
    busRead(4'd0, 32'h3, "buttons_readonly");

    // Dial 0 forward then reverse, then wrap below zero
    applyStimulus(0, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 1'b1);
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0);
    busRead(4'd2, 32'd4, "dial0_fwd4");
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 1'b1);
    busRead(4'd2, 32'd2, "dial0_rev2");
    busWrite(4'd2, 32'd0);
    applyStimulus(0, 1'b0, 1'b1);
    busRead(4'd2, 32'h0000_FFFF, "dial0_wrap");
    busRead(4'd15, 32'd0, "status_clean");

    // Dial 1 invalid jump
    applyStimulus(1, 1'b1, 1'b1);
    busRead(4'd3, 32'd0, "dial1_invalid_hold");
    busRead(4'd15, 32'h2, "status_dial1_err");
    busWrite(4'd15, 32'h2);
    busRead(4'd15, 32'h0, "status_w1c");
    busWrite(4'd3, 32'h0000_1234);
    busRead(4'd3, 32'h0000_1234, "dial1_write");

    // Release button 0 so its debounced state returns to 0
    waitLoadFall(1, p);
    btn = 16'h0002;
    waitLoadFall(6, p);
    busRead(4'd0, 32'h2, "button0_released");
    busRead(4'd1, 32'h0, "events_after_release");

    // Clear of EVENTS[0] in the same clock as its new press
    waitLoadFall(1, p);
    waitLoadFall(1, frame_clks);
    btn = 16'h0003;
    waitLoadFall(3, p);
    repeat (frame_clks - 1) @(posedge clk);
    #1;
    avs_address = 4'd1; avs_writedata = 32'h1; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
    busRead(4'd1, 32'h1, "events_set_beats_clear");
    busRead(4'd0, 32'h3, "buttons_repressed");
    checkOutput("irq_collision", {31'd0, irq}, 32'd1);

    // Dial 0 write in the same clock as a step (01 -> 11)
    @(posedge clk); #1;
    dial_a[0] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    avs_address = 4'd2; avs_writedata = 32'h0000_5555; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
    busRead(4'd2, 32'h0000_5555, "dial0_write_beats_step");
    applyStimulus(0, 1'b1, 1'b0);
    busRead(4'd2, 32'h0000_5556, "dial0_step_after_write");

    repeat (5) @(posedge clk);
    #1;
    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
